// File: rtl/uart_avm_pkg.sv
// Shared definitions for the UART Avalon-MM arbiter: register map, FSM states, command format.
package uart_avm_pkg;
  localparam int AVM_AW = 5;
  localparam int AVM_DW = 32;

  localparam logic [AVM_AW-1:0] RXDATA = 5'd0;
  localparam logic [AVM_AW-1:0] TXDATA = 5'd4;
  localparam logic [AVM_AW-1:0] CTRL   = 5'd8;

  localparam int CTRL_RX_RDY = 7;
  localparam int CTRL_TX_RDY = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              wr;
    logic [AVM_AW-1:0] addr;
    logic [AVM_DW-1:0] wdata;
  } avm_cmd_t;
endpackage

// File: rtl/uart_rr_pick2.sv
// Combinational 2-way round-robin pick: on contention the client not granted last time wins.
module uart_rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant,
  output logic       gnt_id
);
  always_comb begin
    gnt_id = (req == 2'b11) ? ~last : req[1];
    grant  = 2'b00;
    if (|req) grant[gnt_id] = 1'b1;
  end
endmodule

// File: rtl/uart_avm_arbiter.sv
// Shares the UART core's Avalon-MM slave between a TX client (0) and an RX/status poller (1),
// with round-robin grant, waitrequest handling and a stall watchdog.
module uart_avm_arbiter
  import uart_avm_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int AW      = 5,
  parameter int DW      = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_c0_req,
  input  logic          i_c0_wr,
  input  logic [AW-1:0] i_c0_addr,
  input  logic [DW-1:0] i_c0_wdata,
  output logic          o_c0_ack,
  output logic [DW-1:0] o_c0_rdata,
  output logic          o_c0_err,
  input  logic          i_c1_req,
  input  logic          i_c1_wr,
  input  logic [AW-1:0] i_c1_addr,
  input  logic [DW-1:0] i_c1_wdata,
  output logic          o_c1_ack,
  output logic [DW-1:0] o_c1_rdata,
  output logic          o_c1_err,
  output logic [AW-1:0] o_address,
  output logic          o_read,
  output logic          o_write,
  output logic [DW-1:0] o_writedata,
  input  logic [DW-1:0] i_readdata,
  input  logic          i_waitrequest
);
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  arb_state_t           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 wr_q, wr_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic                 last_q, last_d;
  logic [DW-1:0]        rdbuf_q, rdbuf_d;
  logic                 abort_q, abort_d;
  logic [1:0]           ack_q, ack_d;
  logic [1:0]           err_q, err_d;
  logic [1:0][DW-1:0]   rdata_q, rdata_d;

  logic [1:0] req_m, grant;
  logic       gnt_id;

  // A client still sees its req high during its ack cycle; mask it so it is not re-granted.
  assign req_m = {i_c1_req & ~ack_q[1], i_c0_req & ~ack_q[0]};

  uart_rr_pick2 u_pick (
    .req    (req_m),
    .last   (last_q),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    read_d  = read_q;
    write_d = write_q;
    wd_d    = wd_q;
    last_d  = last_q;
    rdbuf_d = rdbuf_q;
    abort_d = abort_q;
    ack_d   = 2'b00;
    err_d   = 2'b00;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (|grant) begin
        owner_d = gnt_id;
        wr_d    = gnt_id ? i_c1_wr    : i_c0_wr;
        addr_d  = gnt_id ? i_c1_addr  : i_c0_addr;
        wdata_d = gnt_id ? i_c1_wdata : i_c0_wdata;
        read_d  = ~wr_d;
        write_d = wr_d;
        wd_d    = '0;
        abort_d = 1'b0;
        state_d = BUS;
      end
      BUS: begin
        if (!i_waitrequest) begin
          if (!wr_q) rdbuf_d = i_readdata;
          read_d  = 1'b0;
          write_d = 1'b0;
          state_d = DONE;
        end else if (wd_q == WD_LAST) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          abort_d = 1'b1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DONE: begin
        ack_d[owner_q] = 1'b1;
        err_d[owner_q] = abort_q;
        // Read data is published together with the ack so rdata never moves ahead of it.
        if (!wr_q && !abort_q) rdata_d[owner_q] = rdbuf_q;
        last_d  = owner_q;
        wd_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      wd_q    <= '0;
      last_q  <= 1'b1;
      rdbuf_q <= '0;
      abort_q <= 1'b0;
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      wd_q    <= wd_d;
      last_q  <= last_d;
      rdbuf_q <= rdbuf_d;
      abort_q <= abort_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_address   = addr_q;
  assign o_writedata = wdata_q;
  assign o_read      = read_q;
  assign o_write     = write_q;
  assign o_c0_ack    = ack_q[0];
  assign o_c1_ack    = ack_q[1];
  assign o_c0_err    = err_q[0];
  assign o_c1_err    = err_q[1];
  assign o_c0_rdata  = rdata_q[0];
  assign o_c1_rdata  = rdata_q[1];
endmodule
